// File: rtl/leaf_switch_if.sv
// Flit bus between a leaf_switch and its four leaf NIs plus the uplink toward the group tier.
// The switch uses the slave modport; the surrounding NIs / upper tier use master.
interface leaf_switch_if #(
  parameter int unsigned DATA_W = 16
);
  logic [4*DATA_W-1:0] leaf_data_in;
  logic [3:0]          leaf_valid_in;
  logic [3:0]          leaf_ready_out;
  logic [4*DATA_W-1:0] leaf_data_out;
  logic [3:0]          leaf_valid_out;
  logic [DATA_W-1:0]   up_data_in;
  logic                up_valid_in;
  logic                up_ready_out;
  logic [DATA_W-1:0]   up_data_out;
  logic                up_valid_out;
  logic                up_ready_in;

  modport slave (
    input  leaf_data_in, leaf_valid_in, up_data_in, up_valid_in, up_ready_in,
    output leaf_ready_out, leaf_data_out, leaf_valid_out, up_ready_out, up_data_out,
           up_valid_out
  );

  modport master (
    output leaf_data_in, leaf_valid_in, up_data_in, up_valid_in, up_ready_in,
    input  leaf_ready_out, leaf_data_out, leaf_valid_out, up_ready_out, up_data_out,
           up_valid_out
  );
endinterface

// File: rtl/leaf_switch.sv
// First-level NoC switch: four leaves plus one uplink, per-input FIFOs, per-output RR arbiters.
// Define LEAF_SW_DROP_CNT_EN to add the saturating drop_cnt output.
module leaf_switch #(
  parameter int unsigned DATA_W   = 16,
  parameter logic [3:0]  GROUP_ID = 4'd1,
  parameter int unsigned IN_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
`ifdef LEAF_SW_DROP_CNT_EN
  output logic [7:0] drop_cnt,
`endif
  leaf_switch_if.slave bus
);
  localparam int unsigned NumPorts = 5;
  localparam int unsigned Uplink   = 4;
  localparam int unsigned PtrW     = $clog2(IN_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt  = CntW'(IN_DEPTH);
  localparam logic [CntW-1:0] ReadyMax = CntW'(IN_DEPTH - 2);

  logic [DATA_W-1:0]   in_data [NumPorts];
  logic [NumPorts-1:0] in_valid;

  logic [DATA_W-1:0]   mem_q    [NumPorts][IN_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q [NumPorts];
  logic [PtrW-1:0]     rd_ptr_q [NumPorts];
  logic [CntW-1:0]     count_q  [NumPorts];
  logic [NumPorts-1:0] push, pop, ready;

  logic [DATA_W-1:0]   head [NumPorts];
  logic [2:0]          dest [NumPorts];
  logic [NumPorts-1:0] fwd, discard;

  logic [2:0]          rr_ptr_q  [NumPorts];
  logic [2:0]          rr_ptr_d  [NumPorts];
  logic [2:0]          grant_idx [NumPorts];
  logic [NumPorts-1:0] grant_any;

  logic [DATA_W-1:0]   out_data_q [NumPorts];
  logic [NumPorts-1:0] out_valid_q;
  logic [4*DATA_W-1:0] leaf_data_flat;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_data[i] = bus.leaf_data_in[i*DATA_W +: DATA_W];
    end
    in_data[Uplink] = bus.up_data_in;
    in_valid        = {bus.up_valid_in, bus.leaf_valid_in};
  end

  // Head decode: local group picks a leaf, otherwise leaves go up and uplink flits are discarded.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      head[i]    = mem_q[i][rd_ptr_q[i]];
      push[i]    = in_valid[i] && (count_q[i] != FullCnt);
      ready[i]   = (count_q[i] <= ReadyMax);
      fwd[i]     = 1'b0;
      discard[i] = 1'b0;
      dest[i]    = 3'(Uplink);
      if (count_q[i] != '0) begin
        if (head[i][DATA_W-1 -: 4] == GROUP_ID) begin
          fwd[i]  = 1'b1;
          dest[i] = {1'b0, head[i][DATA_W-5 -: 2]};
        end else if (i == int'(Uplink)) begin
          discard[i] = 1'b1;
        end else begin
          fwd[i] = 1'b1;
        end
      end
    end
  end

  // Per-output round robin, searching upward from the input after the last winner.
  always_comb begin
    for (int o = 0; o < NumPorts; o++) begin
      int unsigned cand;
      logic        found;
      cand         = 0;
      found        = 1'b0;
      grant_idx[o] = '0;
      rr_ptr_d[o]  = rr_ptr_q[o];
      if ((o != int'(Uplink)) || bus.up_ready_in) begin
        for (int k = 1; k <= NumPorts; k++) begin
          cand = int'(rr_ptr_q[o]) + k;
          if (cand >= NumPorts) begin
            cand = cand - NumPorts;
          end
          if (!found && fwd[cand] && (dest[cand] == 3'(o))) begin
            found        = 1'b1;
            grant_idx[o] = 3'(cand);
          end
        end
      end
      grant_any[o] = found;
      if (found) begin
        rr_ptr_d[o] = grant_idx[o];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      pop[i] = discard[i] || (fwd[i] && grant_any[dest[i]] && (grant_idx[dest[i]] == 3'(i)));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumPorts; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumPorts; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        if (push[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        end
        case ({push[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + 1'b1;
          2'b01:   count_q[i] <= count_q[i] - 1'b1;
          default: count_q[i] <= count_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= '0;
      for (int o = 0; o < NumPorts; o++) begin
        out_data_q[o] <= '0;
        rr_ptr_q[o]   <= 3'd4;
      end
    end else begin
      out_valid_q <= grant_any;
      for (int o = 0; o < NumPorts; o++) begin
        rr_ptr_q[o] <= rr_ptr_d[o];
        if (grant_any[o]) begin
          out_data_q[o] <= head[grant_idx[o]];
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < 4; o++) begin
      leaf_data_flat[o*DATA_W +: DATA_W] = out_data_q[o];
    end
  end

  assign bus.leaf_data_out  = leaf_data_flat;
  assign bus.leaf_valid_out = out_valid_q[3:0];
  assign bus.up_data_out    = out_data_q[Uplink];
  assign bus.up_valid_out   = out_valid_q[Uplink];
  assign bus.leaf_ready_out = ready[3:0];
  assign bus.up_ready_out   = ready[Uplink];

`ifdef LEAF_SW_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  logic [8:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NumPorts; i++) begin
      drop_sum = drop_sum + 9'(in_valid[i] && (count_q[i] == FullCnt));
    end
    drop_sum = drop_sum + 9'(discard[Uplink]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_leaf_switch.sv
// Directed bench for leaf_switch (GROUP_ID=1, IN_DEPTH=4); drop_cnt checks only with
// LEAF_SW_DROP_CNT_EN defined.
module tb_leaf_switch;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] exp_a [3];
  logic [15:0] exp_b [3];

  leaf_switch_if #(.DATA_W(DW)) bus ();
`ifdef LEAF_SW_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  leaf_switch #(
    .DATA_W  (DW),
    .GROUP_ID(4'd1),
    .IN_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef LEAF_SW_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_leaf(input int i, input logic [15:0] d, input logic v);
    bus.leaf_data_in[i*DW +: DW] = d;
    bus.leaf_valid_in[i]         = v;
  endtask

  task automatic clear_inputs();
    bus.leaf_data_in  = '0;
    bus.leaf_valid_in = '0;
    bus.up_data_in    = '0;
    bus.up_valid_in   = 1'b0;
  endtask

  initial begin
    exp_a = '{16'h1C00, 16'h1C01, 16'h1C03};
    exp_b = '{16'h1C11, 16'h1C13, 16'h1C10};
    reset = 1'b1;
    clear_inputs();
    bus.up_ready_in = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_valid", {bus.up_valid_out, bus.leaf_valid_out}, '0);
    check("rst_leaf_data", bus.leaf_data_out, '0);
    check("rst_up_data", bus.up_data_out, '0);
    check("rst_ready", {bus.up_ready_out, bus.leaf_ready_out}, 5'h1F);
`ifdef LEAF_SW_DROP_CNT_EN
    check("rst_drop", drop_cnt, 8'd0);
`endif
    reset = 1'b0;
    tick();

    // Basic local route leaf0 -> leaf2, two-cycle latency
    set_leaf(0, 16'h1805, 1'b1);
    tick();
    set_leaf(0, 16'h0000, 1'b0);
    check("local_early", {bus.up_valid_out, bus.leaf_valid_out}, '0);
    tick();
    check("local_valid", {bus.up_valid_out, bus.leaf_valid_out}, 5'b00100);
    check("local_data", bus.leaf_data_out[2*DW +: DW], 16'h1805);
    tick();
    check("local_pulse", {bus.up_valid_out, bus.leaf_valid_out}, '0);
    check("local_hold", bus.leaf_data_out[2*DW +: DW], 16'h1805);

    // Uplink route held off by up_ready_in
    set_leaf(1, 16'h8C01, 1'b1);
    tick();
    check("bp_ready1", bus.leaf_ready_out[1], 1'b1);
    set_leaf(1, 16'h8C02, 1'b1);
    tick();
    check("bp_ready2", bus.leaf_ready_out[1], 1'b1);
    set_leaf(1, 16'h8C03, 1'b1);
    tick();
    set_leaf(1, 16'h0000, 1'b0);
    check("bp_ready3", bus.leaf_ready_out[1], 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("bp_blocked", bus.up_valid_out, 1'b0);
    end
    bus.up_ready_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("bp_up_valid", bus.up_valid_out, 1'b1);
      check("bp_up_data", bus.up_data_out, 16'h8C00 + 16'(k));
    end
    tick();
    check("bp_drained", bus.up_valid_out, 1'b0);
    check("bp_ready_back", bus.leaf_ready_out[1], 1'b1);

    // Contention on leaf3 output, pointer starting at 4
    set_leaf(0, 16'h1C00, 1'b1);
    set_leaf(1, 16'h1C01, 1'b1);
    set_leaf(3, 16'h1C03, 1'b1);
    tick();
    clear_inputs();
    check("cont_early", bus.leaf_valid_out, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("cont_a_valid", bus.leaf_valid_out, 4'b1000);
      check("cont_a_data", bus.leaf_data_out[3*DW +: DW], exp_a[k]);
    end
    tick();
    check("cont_a_idle", bus.leaf_valid_out, 4'b0000);
    // A lone leaf0 flit leaves the leaf3 pointer at 0
    set_leaf(0, 16'h1C20, 1'b1);
    tick();
    clear_inputs();
    tick();
    check("cont_single", bus.leaf_data_out[3*DW +: DW], 16'h1C20);
    set_leaf(0, 16'h1C10, 1'b1);
    set_leaf(1, 16'h1C11, 1'b1);
    set_leaf(3, 16'h1C13, 1'b1);
    tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("cont_b_valid", bus.leaf_valid_out, 4'b1000);
      check("cont_b_data", bus.leaf_data_out[3*DW +: DW], exp_b[k]);
    end

    // Uplink input: local flit forwarded, foreign flit discarded
    bus.up_data_in  = 16'h1401;
    bus.up_valid_in = 1'b1;
    tick();
    bus.up_valid_in = 1'b0;
    tick();
    check("upin_valid", {bus.up_valid_out, bus.leaf_valid_out}, 5'b00010);
    check("upin_data", bus.leaf_data_out[1*DW +: DW], 16'h1401);
    bus.up_data_in  = 16'h2001;
    bus.up_valid_in = 1'b1;
    tick();
    bus.up_valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("upin_foreign", {bus.up_valid_out, bus.leaf_valid_out}, '0);
    end
    check("upin_ready", bus.up_ready_out, 1'b1);
`ifdef LEAF_SW_DROP_CNT_EN
    check("upin_drop", drop_cnt, 8'd1);
`endif

    // Overflow: fill leaf0 FIFO while uplink blocked, then one extra flit
    bus.up_ready_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_leaf(0, 16'hA000 + 16'(k), 1'b1);
      tick();
    end
    check("ovf_ready", bus.leaf_ready_out[0], 1'b0);
    check("ovf_blocked", bus.up_valid_out, 1'b0);
    set_leaf(0, 16'hA005, 1'b1);
    tick();
    set_leaf(0, 16'h0000, 1'b0);
`ifdef LEAF_SW_DROP_CNT_EN
    check("ovf_drop", drop_cnt, 8'd2);
`endif
    bus.up_ready_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("ovf_valid", bus.up_valid_out, 1'b1);
      check("ovf_data", bus.up_data_out, 16'hA000 + 16'(k));
    end
    tick();
    check("ovf_no_extra", bus.up_valid_out, 1'b0);

    // Reset mid-traffic with three flits queued at leaf2
    bus.up_ready_in = 1'b0;
    set_leaf(2, 16'hB001, 1'b1);
    tick();
    set_leaf(2, 16'hB002, 1'b1);
    tick();
    set_leaf(2, 16'hB003, 1'b1);
    set_leaf(1, 16'h1002, 1'b1);
    tick();
    clear_inputs();
    tick();
    check("mid_pre_valid", bus.leaf_valid_out, 4'b0001);
    check("mid_pre_ready", bus.leaf_ready_out[2], 1'b0);
    reset = 1'b1;
    #1;
    check("mid_valid", {bus.up_valid_out, bus.leaf_valid_out}, '0);
    check("mid_data", bus.leaf_data_out, '0);
    check("mid_ready", {bus.up_ready_out, bus.leaf_ready_out}, 5'h1F);
`ifdef LEAF_SW_DROP_CNT_EN
    check("mid_drop", drop_cnt, 8'd0);
`endif
    #2;
    reset = 1'b0;
    bus.up_ready_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post_rst_quiet", {bus.up_valid_out, bus.leaf_valid_out}, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
